// File: rtl/quad_pkg.sv
// Shared quadrature definitions: phase encoding, decoder states and
// transition classification. Phase constants are also used by joy2quad.
package quad_pkg;

    // Increment order of {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b10;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b01;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_INC,
        TR_DEC,
        TR_ERR
    } trans_t;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        case (ph)
            PH_0:    next_phase = PH_1;
            PH_1:    next_phase = PH_2;
            PH_2:    next_phase = PH_3;
            default: next_phase = PH_0;
        endcase
    endfunction

    function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] curr);
        if (curr == prev)
            classify = TR_NONE;
        else if (curr == next_phase(prev))
            classify = TR_INC;
        else if (prev == next_phase(curr))
            classify = TR_DEC;
        else
            classify = TR_ERR;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-FF synchroniser followed by a stability filter that
// accepts a new level only after it has persisted for FILT_LEN cycles.
module quad_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic stable
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] FULL  = CW'(FILT_LEN);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] chg_cnt;
    logic [CW-1:0] hold_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            level    <= 1'b0;
            chg_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 != level) begin
                hold_cnt <= '0;
                if (chg_cnt == LIMIT) begin
                    level   <= sync_2;
                    chg_cnt <= '0;
                end else begin
                    chg_cnt <= chg_cnt + CW'(1);
                end
            end else begin
                chg_cnt <= '0;
                if (hold_cnt != FULL)
                    hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

    // Level has matched the synchronised input for FILT_LEN cycles
    assign stable = (hold_cnt == FULL);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature paddle decoder: filtered A/B channels drive a saturating position,
// step/error pulses, an error counter and an activity indicator.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 4,
    parameter logic [7:0]  POS_RESET   = 8'h80,
    parameter logic [23:0] IDLE_CYCLES = 24'd12000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       pos_load,
    input  logic [7:0] pos_load_val,
    output logic [7:0] position,
    output logic       dir,
    output logic       step_pulse,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic       active
);

    logic        level_a;
    logic        level_b;
    logic        stable_a;
    logic        stable_b;
    logic [1:0]  ab_q;
    logic [1:0]  prev_ab;
    state_t      state;
    trans_t      trans;
    logic        step_fire;
    logic [23:0] idle_cnt;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (enc_a),
        .level   (level_a),
        .stable  (stable_a)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (enc_b),
        .level   (level_b),
        .stable  (stable_b)
    );

    always_comb begin
        trans = TR_NONE;
        if (state == ST_TRACK)
            trans = classify(prev_ab, ab_q);
    end

    // A load in the same cycle swallows the step entirely
    assign step_fire = ((trans == TR_INC) || (trans == TR_DEC)) && !pos_load;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_INIT;
            ab_q       <= '0;
            prev_ab    <= '0;
            position   <= POS_RESET;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            ab_q       <= {level_a, level_b};
            step_pulse <= step_fire;
            err_pulse  <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (stable_a && stable_b) begin
                        prev_ab <= ab_q;
                        state   <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (trans != TR_NONE)
                        prev_ab <= ab_q;
                    if (step_fire) begin
                        dir <= (trans == TR_INC);
                        if (trans == TR_INC)
                            position <= (position == 8'hFF) ? position : position + 8'd1;
                        else
                            position <= (position == 8'h00) ? position : position - 8'd1;
                    end
                    if (trans == TR_ERR) begin
                        err_pulse <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
            if (pos_load)
                position <= pos_load_val;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            idle_cnt <= '0;
        else if (step_fire)
            idle_cnt <= IDLE_CYCLES;
        else if (idle_cnt != '0)
            idle_cnt <= idle_cnt - 24'd1;
    end

    assign active = (idle_cnt != '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a cycle-level reference model predicts
// pulses and outputs from raw encoder samples; a negedge monitor compares.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int FL   = 4;
    localparam int IDLE = 100;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       pos_load;
    logic [7:0] pos_load_val;
    logic [7:0] position;
    logic       dir;
    logic       step_pulse;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       active;

    quad_decoder #(
        .FILT_LEN    (FL),
        .POS_RESET   (8'h80),
        .IDLE_CYCLES (24'd100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .pos_load     (pos_load),
        .pos_load_val (pos_load_val),
        .position     (position),
        .dir          (dir),
        .step_pulse   (step_pulse),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt),
        .active       (active)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int kind; int pos; int dir; int err; int due; } exp_t; // kind 1=step 2=err
    typedef struct { int due; logic [1:0] ab; } pend_t;

    exp_t       sb[$];
    pend_t      pend[$];
    logic       hq_a[$];
    logic       hq_b[$];
    logic       m_la = 1'b0, m_lb = 1'b0;
    bit         m_track = 1'b0;
    logic [1:0] m_prev = 2'b00;
    int         m_pos = 128, m_dir = 0, m_err = 0, m_idle = 0;
    int         phase_idx[4] = '{0, 3, 1, 2};   // ab 00->0, 01->3, 10->1, 11->2
    logic [1:0] ab_of[4]     = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic bit window_flips(input logic q[$], input logic lvl);
        for (int i = 0; i < FL; i++)
            if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    pend_t p;
    exp_t  e;
    int    d;
    bit    chg, stepped, errfire;

    always @(posedge clk_sys) begin
        cyc = cyc + 1;
        if (reset) begin
            hq_a = {};
            hq_b = {};
            for (int i = 0; i < FL + 2; i++) begin
                hq_a.push_back(1'b0);
                hq_b.push_back(1'b0);
            end
            m_la = 1'b0; m_lb = 1'b0; m_track = 1'b0; m_prev = 2'b00;
            m_pos = 128; m_dir = 0; m_err = 0; m_idle = 0;
            pend = {};
            sb = {};
        end else begin
            hq_a.push_back(enc_a); void'(hq_a.pop_front());
            hq_b.push_back(enc_b); void'(hq_b.pop_front());
            chg = 1'b0;
            if (window_flips(hq_a, m_la)) begin m_la = !m_la; chg = 1'b1; end
            if (window_flips(hq_b, m_lb)) begin m_lb = !m_lb; chg = 1'b1; end
            if (chg && m_track) begin
                p.due = cyc + 2;
                p.ab  = {m_la, m_lb};
                pend.push_back(p);
            end
            stepped = 1'b0;
            errfire = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                d = (phase_idx[p.ab] - phase_idx[m_prev] + 4) % 4;
                m_prev = p.ab;
                if ((d == 1 || d == 3) && !pos_load) begin
                    m_dir = (d == 1) ? 1 : 0;
                    if (d == 1) m_pos = (m_pos < 255) ? m_pos + 1 : 255;
                    else        m_pos = (m_pos > 0) ? m_pos - 1 : 0;
                    stepped = 1'b1;
                end else if (d == 2) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    errfire = 1'b1;
                end
            end
            if (pos_load) m_pos = int'(pos_load_val);
            if (stepped || errfire) begin
                e.kind = stepped ? 1 : 2;
                e.pos = m_pos; e.dir = m_dir; e.err = m_err; e.due = cyc;
                sb.push_back(e);
            end
            m_idle = stepped ? IDLE : ((m_idle > 0) ? m_idle - 1 : 0);
        end
    end

    // ---------------- monitor ----------------
    int n_steps = 0;
    int n_errs  = 0;
    int step_cycles[$];
    exp_t got;

    always @(negedge clk_sys) begin
        check("position", int'(position), m_pos);
        check("dir", int'(dir), m_dir);
        check("err_cnt", int'(err_cnt), m_err);
        check("active", int'(active), (m_idle != 0) ? 1 : 0);
        if (step_pulse || err_pulse) begin
            if (step_pulse) begin n_steps++; step_cycles.push_back(cyc); end
            if (err_pulse) n_errs++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {step_pulse, err_pulse}, 0);
            end else begin
                got = sb.pop_front();
                check("pulse_kind", step_pulse ? (err_pulse ? 3 : 1) : 2, got.kind);
                check("pulse_cycle", cyc, got.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            got = sb.pop_front();
            check("missing_pulse", 0, got.kind);
        end
    end

    // ---------------- stimulus ----------------
    int ph = 2;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        enc_a = ab[1];
        enc_b = ab[0];
        tick(n);
    endtask

    task automatic start_track();
        m_prev  = {m_la, m_lb};
        m_track = 1'b1;
    endtask

    int s0, e0, t0, k, cnt, hl;

    initial begin
        reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; pos_load = 1'b0; pos_load_val = 8'h00;
        tick(3);
        check("reset_position", int'(position), 8'h80);
        check("reset_err_cnt", int'(err_cnt), 0);
        check("reset_active", int'(active), 0);
        reset = 1'b0;

        // Idle with A=B=1 after reset
        hold(2'b11, 20);
        check("init_position", int'(position), 8'h80);
        check("init_no_pulses", n_steps + n_errs, 0);
        check("init_state_track", (dut.state == ST_TRACK) ? 1 : 0, 1);
        start_track();

        // Ten increments, 8-cycle holds, with latency of the first
        s0 = n_steps; step_cycles = {}; t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            ph = (ph + 1) % 4;
            hold(ab_of[ph], 8);
        end
        tick(4);
        check("inc_position", int'(position), 8'h8A);
        check("inc_dir", int'(dir), 1);
        check("inc_steps", n_steps - s0, 10);
        check("inc_first_latency", (step_cycles.size() > 0) ? step_cycles[0] - (t0 + 1) : -1, 7);

        // 2-cycle glitches on A (phase is 00 here)
        s0 = n_steps; e0 = n_errs;
        for (int i = 0; i < 5; i++) begin
            hold({1'b1, ab_of[ph][0]}, 2);
            hold(ab_of[ph], 18);
        end
        check("glitch_position", int'(position), 8'h8A);
        check("glitch_pulses", (n_steps - s0) + (n_errs - e0), 0);

        // Two-bit jumps 00 <-> 11
        e0 = n_errs;
        hold(2'b11, 8); hold(2'b00, 8); hold(2'b11, 8);
        tick(2);
        check("err3_cnt", int'(err_cnt), 3);
        check("err3_position", int'(position), 8'h8A);
        check("err3_pulses", n_errs - e0, 3);
        for (int i = 0; i < 300; i++)
            hold((i % 2 == 0) ? 2'b00 : 2'b11, 8);
        tick(2);
        check("err_sat_cnt", int'(err_cnt), 255);
        check("err_sat_pulses", n_errs - e0, 303);
        ph = 2;

        // Load 0xFE then five increments saturate at 0xFF
        pos_load_val = 8'hFE; pos_load = 1'b1; tick(1); pos_load = 1'b0;
        check("load_position", int'(position), 8'hFE);
        s0 = n_steps;
        for (int i = 0; i < 5; i++) begin
            ph = (ph + 1) % 4;
            hold(ab_of[ph], 8);
        end
        tick(4);
        check("sat_position", int'(position), 8'hFF);
        check("sat_steps", n_steps - s0, 5);
        check("sat_dir", int'(dir), 1);

        // Load coincident with a step: step edge is 8 edges after the drive
        s0 = n_steps;
        ph = (ph + 1) % 4;
        enc_a = ab_of[ph][1]; enc_b = ab_of[ph][0];
        tick(7);
        pos_load_val = 8'h33; pos_load = 1'b1;
        tick(1);
        pos_load = 1'b0;
        tick(6);
        check("coinc_position", int'(position), 8'h33);
        check("coinc_no_step", n_steps - s0, 0);

        // One decrement step, then idle: active for exactly IDLE cycles
        s0 = n_steps;
        ph = (ph + 3) % 4;
        enc_a = ab_of[ph][1]; enc_b = ab_of[ph][0];
        k = 0;
        while (n_steps == s0 && k < 30) begin tick(1); k++; end
        check("idle_step_seen", n_steps - s0, 1);
        check("idle_dir", int'(dir), 0);
        cnt = 0;
        while (active && cnt < 300) begin cnt++; tick(1); end
        check("active_cycles", cnt, IDLE);

        // Reset in the middle of a transition
        ph = (ph + 1) % 4;
        enc_a = ab_of[ph][1]; enc_b = ab_of[ph][0];
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        s0 = n_steps; e0 = n_errs;
        tick(20);
        check("rst_mid_position", int'(position), 8'h80);
        check("rst_mid_err_cnt", int'(err_cnt), 0);
        check("rst_mid_pulses", (n_steps - s0) + (n_errs - e0), 0);
        check("rst_mid_state_track", (dut.state == ST_TRACK) ? 1 : 0, 1);
        start_track();

        // Random phases, holds and loads
        for (int i = 0; i < 300; i++) begin
            enc_a = 1'($urandom_range(0, 1));
            enc_b = 1'($urandom_range(0, 1));
            hl = int'($urandom_range(1, 12));
            for (int j = 0; j < hl; j++) begin
                pos_load = ($urandom_range(0, 19) == 0);
                pos_load_val = 8'($urandom);
                tick(1);
            end
            pos_load = 1'b0;
        end
        tick(20);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
